// File: rtl/control_unit.sv
// Instruction-sequencing FSM for the simple 16-bit processor: fetches a 9-bit
// instruction and steps mv/mvi/add/sub through T0..T3. Define CTRL_MVNZ_EN to add mvnz.
module control_unit #(
  parameter int IR_W = 9,
  parameter int NREG = 8
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            run,
  input  logic [15:0]     din,
  input  logic            g_nz,
  output logic            ir_in,
  output logic [NREG-1:0] r_in,
  output logic            a_in,
  output logic            g_in,
  output logic            add_sub,
  output logic [7:0]      sel_r,
  output logic            sel_g,
  output logic            sel_din,
  output logic            done
);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} tstep_e;

  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_MVNZ = 3'b100
  } opcode_e;

  tstep_e            tstep_q, tstep_d;
  logic [IR_W-1:0]   ir_q, ir_d;

  opcode_e           opcode;
  logic [2:0]        rx, ry;
  logic              is_arith;

  assign opcode   = opcode_e'(ir_q[IR_W-1 -: 3]);
  assign rx       = ir_q[5:3];
  assign ry       = ir_q[2:0];
  assign is_arith = (opcode == OP_ADD) || (opcode == OP_SUB);

  // din[15:9] is only data, never instruction; g_nz matters only with mvnz.
`ifdef CTRL_MVNZ_EN
  logic unused_din;
  assign unused_din = ^din[15:IR_W];
`else
  logic unused_din;
  assign unused_din = ^{din[15:IR_W], g_nz};
`endif

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value held over from the previous evaluation (which would infer a latch).
  always_comb begin
    tstep_d = tstep_q;
    ir_d    = ir_q;
    ir_in   = 1'b0;
    r_in    = '0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    add_sub = 1'b0;
    sel_r   = '0;
    sel_g   = 1'b0;
    sel_din = 1'b0;
    done    = 1'b0;

    unique case (tstep_q)
      T0: begin
        if (run) begin
          ir_in   = 1'b1;
          ir_d    = din[IR_W-1:0];
          tstep_d = T1;
        end
      end

      T1: begin
        tstep_d = T0;
        case (opcode)
          OP_MV: begin
            sel_r = {5'b0, ry};
            r_in  = NREG'(1) << rx;
            done  = 1'b1;
          end
          OP_MVI: begin
            sel_din = 1'b1;
            r_in    = NREG'(1) << rx;
            done    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            sel_r   = {5'b0, rx};
            a_in    = 1'b1;
            tstep_d = T2;
          end
`ifdef CTRL_MVNZ_EN
          OP_MVNZ: begin
            if (g_nz) begin
              sel_r = {5'b0, ry};
              r_in  = NREG'(1) << rx;
            end
            done = 1'b1;
          end
`endif
          default: done = 1'b1;
        endcase
      end

      T2: begin
        tstep_d = T0;
        if (is_arith) begin
          sel_r   = {5'b0, ry};
          g_in    = 1'b1;
          add_sub = (opcode == OP_SUB);
          tstep_d = T3;
        end
      end

      T3: begin
        tstep_d = T0;
        if (is_arith) begin
          sel_g = 1'b1;
          r_in  = NREG'(1) << rx;
          done  = 1'b1;
        end
      end

      default: tstep_d = T0;
    endcase

    // Outputs must be quiet the moment resetn falls, before state has settled.
    if (!resetn) begin
      ir_in   = 1'b0;
      r_in    = '0;
      a_in    = 1'b0;
      g_in    = 1'b0;
      add_sub = 1'b0;
      sel_r   = '0;
      sel_g   = 1'b0;
      sel_din = 1'b0;
      done    = 1'b0;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tstep_q <= T0;
      ir_q    <= '0;
    end else begin
      tstep_q <= tstep_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus pushes per-cycle expected
// outputs, a monitor pops and compares on the falling clock edge.
module tb_control_unit;

  typedef struct packed {
    logic       ir_in;
    logic [7:0] r_in;
    logic       a_in;
    logic       g_in;
    logic       add_sub;
    logic [7:0] sel_r;
    logic       sel_g;
    logic       sel_din;
    logic       done;
  } outs_t;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        run = 1'b0;
  logic [15:0] din = '0;
  logic        g_nz = 1'b0;

  logic        ir_in, a_in, g_in, add_sub, sel_g, sel_din, done;
  logic [7:0]  r_in, sel_r;

  outs_t       exp_q[$];
  string       name_q[$];
  int          errors = 0;
  int          checks = 0;

  control_unit #(.IR_W(9), .NREG(8)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .run     (run),
    .din     (din),
    .g_nz    (g_nz),
    .ir_in   (ir_in),
    .r_in    (r_in),
    .a_in    (a_in),
    .g_in    (g_in),
    .add_sub (add_sub),
    .sel_r   (sel_r),
    .sel_g   (sel_g),
    .sel_din (sel_din),
    .done    (done)
  );

  always #5 clock = ~clock;

  function automatic outs_t mk(input logic ir, input logic [7:0] r, input logic a,
                               input logic g, input logic as, input logic [7:0] sr,
                               input logic sg, input logic sd, input logic dn);
    outs_t o;
    o.ir_in = ir; o.r_in = r; o.a_in = a; o.g_in = g; o.add_sub = as;
    o.sel_r = sr; o.sel_g = sg; o.sel_din = sd; o.done = dn;
    return o;
  endfunction

  localparam outs_t ZERO  = '0;
  localparam outs_t FETCH = '{ir_in: 1'b1, default: '0};
  localparam outs_t DONE  = '{done: 1'b1, default: '0};

  task automatic check(input string name, input outs_t act, input outs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %06h expected %06h", name, act, exp);
    end
  endtask

  // One stimulus cycle: drive inputs just after the rising edge and queue the
  // outputs the design must show during this cycle.
  task automatic cyc(input string name, input logic rn, input logic rv,
                     input logic [15:0] d, input logic gz, input outs_t exp);
    @(posedge clock);
    #1;
    resetn = rn;
    run    = rv;
    din    = d;
    g_nz   = gz;
    exp_q.push_back(exp);
    name_q.push_back(name);
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      outs_t act;
      act = '{ir_in, r_in, a_in, g_in, add_sub, sel_r, sel_g, sel_din, done};
      check(name_q.pop_front(), act, exp_q.pop_front());
    end
  end

  initial begin
    outs_t mvnz_g1;
`ifdef CTRL_MVNZ_EN
    mvnz_g1 = mk(0, 8'h08, 0, 0, 0, 8'd0, 0, 0, 1);
`else
    mvnz_g1 = DONE;
`endif

    // Reset held with run high: everything quiet.
    cyc("rst_hold0", 0, 1, 16'o001, 0, ZERO);
    cyc("rst_hold1", 0, 1, 16'o001, 0, ZERO);
    // mvi R0,#5
    cyc("mvi_t0", 1, 1, 16'b001_000_000, 0, FETCH);
    cyc("mvi_t1", 1, 0, 16'd5, 0, mk(0, 8'h01, 0, 0, 0, 8'd0, 0, 1, 1));
    // mv R1,R0 with run held high, then back-to-back sub R2,R1
    cyc("mv_t0", 1, 1, 16'b000_001_000, 0, FETCH);
    cyc("mv_t1", 1, 1, 16'h0000, 0, mk(0, 8'h02, 0, 0, 0, 8'd0, 0, 0, 1));
    cyc("sub_t0", 1, 1, 16'b011_010_001, 0, FETCH);
    cyc("sub_t1", 1, 0, 16'h0000, 0, mk(0, 8'h00, 1, 0, 0, 8'd2, 0, 0, 0));
    cyc("sub_t2", 1, 0, 16'h0000, 0, mk(0, 8'h00, 0, 1, 1, 8'd1, 0, 0, 0));
    cyc("sub_t3", 1, 0, 16'h0000, 0, mk(0, 8'h04, 0, 0, 0, 8'd0, 1, 0, 1));
    cyc("idle", 1, 0, 16'h0000, 0, ZERO);
    // add R3,R3 aborted by reset in T2
    cyc("add33_t0", 1, 1, 16'b010_011_011, 0, FETCH);
    cyc("add33_t1", 1, 1, 16'h0000, 0, mk(0, 8'h00, 1, 0, 0, 8'd3, 0, 0, 0));
    cyc("rst_mid_t2", 0, 1, 16'h0000, 0, ZERO);
    cyc("rst_mid_hold", 0, 1, 16'h0000, 0, ZERO);
    // Opcode 100 with g_nz low, then high
    cyc("op4_g0_t0", 1, 1, 16'b100_011_000, 0, FETCH);
    cyc("op4_g0_t1", 1, 1, 16'b100_011_000, 0, DONE);
    cyc("op4_g1_t0", 1, 1, 16'b100_011_000, 1, FETCH);
    cyc("op4_g1_t1", 1, 0, 16'h0000, 1, mvnz_g1);
    // NOP opcode 111 must not write even with g_nz high
    cyc("nop7_t0", 1, 1, 16'b111_101_010, 1, FETCH);
    cyc("nop7_t1", 1, 0, 16'h0000, 1, DONE);
    // add R1,R2 to cover add_sub=0 and a different destination
    cyc("add12_t0", 1, 1, 16'b010_001_010, 0, FETCH);
    cyc("add12_t1", 1, 0, 16'h0000, 0, mk(0, 8'h00, 1, 0, 0, 8'd1, 0, 0, 0));
    cyc("add12_t2", 1, 0, 16'h0000, 0, mk(0, 8'h00, 0, 1, 0, 8'd2, 0, 0, 0));
    cyc("add12_t3", 1, 0, 16'h0000, 0, mk(0, 8'h02, 0, 0, 0, 8'd0, 1, 0, 1));
    cyc("idle_end", 1, 0, 16'h0000, 0, ZERO);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
